sgi_irq_ctrl: RTL and testbench

//  Per-tile interrupt controller directly downstream of the tile SFR block.

---
 rtl/sgi_irq_ctrl_pkg.sv | 18 +
 rtl/mem_split32.sv | 19 +
 rtl/sgi_irq_ctrl_prio_enc.sv | 24 ++
 rtl/sgi_irq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sgi_irq_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgi_irq_ctrl_pkg.sv
// Shared definitions for the tile interrupt controller.
// Contents:
//   irqc_state_e    delivery FSM states (IDLE, REQ, SERVICE), 2-bit encoding
//                   that is exposed directly in the STATUS register
//   IRQC_*_ADDR     host register offsets (addr[7:0])
package sgi_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irqc_state_e;

  localparam logic [7:0] IRQC_MASK_ADDR = 8'h00;
  localparam logic [7:0] IRQC_PEND_ADDR = 8'h04;
  localparam logic [7:0] IRQC_STAT_ADDR = 8'h08;

endpackage

// File: rtl/mem_split32.sv
// MemSplit32 register-access bus: split request / response channel.
// Signals:
//   req, we, addr, wdata   master -> slave request
//   ack                    slave accepts the request
//   resp, rdata            read response, one beat
interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Master (output req, output we, output addr, output wdata,
                  input ack, input resp, input rdata);
  modport Slave  (input req, input we, input addr, input wdata,
                  output ack, output resp, output rdata);
endinterface

// File: rtl/sgi_irq_ctrl_prio_enc.sv
// Fixed-priority encoder, purely combinational.
// Ports:
//   vec    N-bit request vector
//   valid  1 when any bit of vec is set
//   idx    index of the lowest set bit (0 when vec is empty)
module irq_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/sgi_irq_ctrl.sv
// Per-tile interrupt controller. Merges software-generated interrupts with
// rising-edge external irq lines into a pending set, gates it with a mask,
// and delivers one interrupt at a time to the core via req/ack/eoi.
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-low reset
//   host         MemSplit32 slave: 0x0 MASK rw, 0x4 PENDING r / W1C,
//                0x8 STATUS r {code[15:8], state[3:2], req[0]}
//   sgi_req_i    one-cycle SGI strobe, sgi_code_bi selects the line
//   irq_bi       external irq lines, rising-edge triggered
//   irq_req_o    request to the core, irq_code_bo holds the line index
//   irq_ack_i    core accepted the request
//   irq_eoi_i    core finished the handler
// Build option:
//   SGI_IRQ_CTRL_EXT_SYNC_EN  adds a 2-flop synchronizer on irq_bi ahead of
//                             the edge detector (two extra cycles of latency)
module sgi_irq_ctrl
  import sgi_irq_ctrl_pkg::*;
#(
  parameter int                          IRQ_NUM_POW      = 4,
  parameter logic [2**IRQ_NUM_POW-1:0]   IRQ_MASK_DEFAULT = '1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  MemSplit32.Slave                     host,
  input  logic                         sgi_req_i,
  input  logic [IRQ_NUM_POW-1:0]       sgi_code_bi,
  input  logic [2**IRQ_NUM_POW-1:0]    irq_bi,
  output logic                         irq_req_o,
  output logic [IRQ_NUM_POW-1:0]       irq_code_bo,
  input  logic                         irq_ack_i,
  input  logic                         irq_eoi_i
);

  localparam int N = 2**IRQ_NUM_POW;

  irqc_state_e            state_q, state_d;
  logic [IRQ_NUM_POW-1:0] code_q, code_d;
  logic [N-1:0]           pending_q, mask_q, irq_hist_q;
  logic [N-1:0]           irq_src, irq_rise, sgi_set, w1c_clr, ack_clr, armed;
  logic                   pick_valid;
  logic [IRQ_NUM_POW-1:0] pick_idx;
  logic                   host_wr, host_rd, resp_q;
  logic [7:0]             host_addr;
  logic [31:0]            rd_data, rdata_q;
  logic                   unused_host;

  assign host_addr   = host.addr[7:0];
  assign host_wr     = host.req & host.we;
  assign host_rd     = host.req & ~host.we;
  assign unused_host = ^{host.addr[31:8], host.wdata};

  assign host.ack    = host.req;
  assign host.resp   = resp_q;
  assign host.rdata  = rdata_q;

`ifdef SGI_IRQ_CTRL_EXT_SYNC_EN
  // External lines may be asynchronous; resynchronize before edge detection.
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_bi;
      sync2_q <= sync1_q;
    end
  end

  assign irq_src = sync2_q;
`else
  assign irq_src = irq_bi;
`endif

  assign irq_rise = irq_src & ~irq_hist_q;

  // Set and clear sources for the pending vector. Clears come from the host
  // W1C and from the ack that moves a code into service.
  always_comb begin
    sgi_set = '0;
    ack_clr = '0;
    w1c_clr = '0;
    if (sgi_req_i) sgi_set[sgi_code_bi] = 1'b1;
    if (state_q == REQ && irq_ack_i) ack_clr[code_q] = 1'b1;
    if (host_wr && host_addr == IRQC_PEND_ADDR) w1c_clr = host.wdata[N-1:0];
  end

  // Sets are ORed in after the clears so a same-cycle event is never lost.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pending_q  <= '0;
      mask_q     <= IRQ_MASK_DEFAULT;
      irq_hist_q <= '0;
    end else begin
      pending_q  <= (pending_q & ~(w1c_clr | ack_clr)) | sgi_set | irq_rise;
      irq_hist_q <= irq_src;
      if (host_wr && host_addr == IRQC_MASK_ADDR) mask_q <= host.wdata[N-1:0];
    end
  end

  assign armed = pending_q & mask_q;

  irq_prio_enc #(
    .N (N),
    .W (IRQ_NUM_POW)
  ) u_prio_enc (
    .vec   (armed),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Delivery FSM state register; the code stays latched until the next pick.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic. Once in REQ the code is held even if its mask bit drops.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          code_d  = pick_idx;
          state_d = REQ;
        end
      end
      REQ:     if (irq_ack_i) state_d = SERVICE;
      SERVICE: if (irq_eoi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign irq_req_o   = (state_q == REQ);
  assign irq_code_bo = code_q;

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    rd_data = '0;
    case (host_addr)
      IRQC_MASK_ADDR: rd_data[N-1:0] = mask_q;
      IRQC_PEND_ADDR: rd_data[N-1:0] = pending_q;
      IRQC_STAT_ADDR: begin
        rd_data[0]                = irq_req_o;
        rd_data[3:2]              = state_q;
        rd_data[8 +: IRQ_NUM_POW] = code_q;
      end
      default: ;
    endcase
  end

  // Reads respond one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= host_rd;
      if (host_rd) rdata_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_sgi_irq_ctrl.sv
// Directed testbench for sgi_irq_ctrl (default build, N = 16 lines).
module tb_sgi_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sgi_req;
  logic [3:0]  sgi_code;
  logic [15:0] irq_bi;
  logic        irq_req;
  logic [3:0]  irq_code;
  logic        irq_ack;
  logic        irq_eoi;

  int tests_run;
  int tests_failed;

  MemSplit32 host_if ();

  sgi_irq_ctrl #(
    .IRQ_NUM_POW      (4),
    .IRQ_MASK_DEFAULT (16'hFFFF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .host        (host_if),
    .sgi_req_i   (sgi_req),
    .sgi_code_bi (sgi_code),
    .irq_bi      (irq_bi),
    .irq_req_o   (irq_req),
    .irq_code_bo (irq_code),
    .irq_ack_i   (irq_ack),
    .irq_eoi_i   (irq_eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set before this are sampled at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    host_if.req   = 1'b1;
    host_if.we    = 1'b1;
    host_if.addr  = {24'h0, a};
    host_if.wdata = d;
    tick();
    host_if.req   = 1'b0;
    host_if.we    = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d, output logic r);
    host_if.req  = 1'b1;
    host_if.we   = 1'b0;
    host_if.addr = {24'h0, a};
    tick();
    d = host_if.rdata;
    r = host_if.resp;
    host_if.req  = 1'b0;
  endtask

  task automatic sgi(input logic [3:0] c);
    sgi_req  = 1'b1;
    sgi_code = c;
    tick();
    sgi_req  = 1'b0;
  endtask

  task automatic serve();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rs;
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req: got %b want 0", irq_req); end
    tests_run++;
    if (irq_code !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_code: got %h want 0", irq_code); end
    tests_run++;
    if (host_if.resp !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp: got %b want 0", host_if.resp); end
    rst_n = 1'b1;
    host_if.req = 1'b1;
    #1;
    tests_run++;
    if (host_if.ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL host_ack_hi: got %b want 1", host_if.ack); end
    host_if.req = 1'b0;
    #1;
    tests_run++;
    if (host_if.ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL host_ack_lo: got %b want 0", host_if.ack); end
    host_read(8'h00, rd, rs);
    tests_run++;
    if (rs !== 1'b1) begin tests_failed++; $display("[TB] FAIL read_resp: got %b want 1", rs); end
    tests_run++;
    if (rd !== 32'h0000_FFFF) begin tests_failed++; $display("[TB] FAIL reset_mask: got %h want 0000ffff", rd); end
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pend: got %h want 0", rd); end
    host_read(8'h08, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_stat: got %h want 0", rd); end
    host_write(8'h0C, 32'h1234_5678);
    host_read(8'h0C, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL unmapped_read: got %h want 0", rd); end
  endtask

  task automatic test_sgi();
    logic [31:0] rd;
    logic        rs;
    sgi(4'd5);
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL sgi_early: got %b want 0", irq_req); end
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd5) begin
      tests_failed++; $display("[TB] FAIL sgi_deliver: got req=%b code=%0d want req=1 code=5", irq_req, irq_code);
    end
    host_read(8'h08, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_0505) begin tests_failed++; $display("[TB] FAIL sgi_stat_req: got %h want 00000505", rd); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL sgi_service_req: got %b want 0", irq_req); end
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL sgi_pend_clr: got %h want 0", rd); end
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    host_read(8'h08, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_0500) begin tests_failed++; $display("[TB] FAIL sgi_stat_idle: got %h want 00000500", rd); end
  endtask

  task automatic test_priority();
    logic [31:0] rd;
    logic        rs;
    irq_bi = 16'h0208;
    tick();
`ifdef SGI_IRQ_CTRL_EXT_SYNC_EN
    tick();
    tick();
`endif
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_early: got %b want 0", irq_req); end
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd3) begin
      tests_failed++; $display("[TB] FAIL prio_first: got req=%b code=%0d want req=1 code=3", irq_req, irq_code);
    end
    serve();
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_gap: got %b want 0", irq_req); end
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd9) begin
      tests_failed++; $display("[TB] FAIL prio_second: got req=%b code=%0d want req=1 code=9", irq_req, irq_code);
    end
    serve();
    tick();
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_level_hold: got %b want 0", irq_req); end
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL prio_pend: got %h want 0", rd); end
    irq_bi = 16'h0;
    tick();
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    logic        rs;
    host_write(8'h00, 32'h0000_FFFB);
    sgi(4'd2);
    tick();
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_block: got %b want 0", irq_req); end
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_0004) begin tests_failed++; $display("[TB] FAIL mask_pend: got %h want 00000004", rd); end
    host_read(8'h00, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_FFFB) begin tests_failed++; $display("[TB] FAIL mask_read: got %h want 0000fffb", rd); end
    host_write(8'h00, 32'h0000_FFFF);
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_unmask_early: got %b want 0", irq_req); end
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd2) begin
      tests_failed++; $display("[TB] FAIL mask_deliver: got req=%b code=%0d want req=1 code=2", irq_req, irq_code);
    end
    serve();
    host_write(8'h00, 32'hFFFF_0000);
    host_read(8'h00, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL mask_upper_bits: got %h want 0", rd); end
    sgi(4'd6);
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_0040) begin tests_failed++; $display("[TB] FAIL w1c_before: got %h want 00000040", rd); end
    host_write(8'h04, 32'h0000_0040);
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL w1c_after: got %h want 0", rd); end
    host_write(8'h00, 32'h0000_FFFF);
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    logic        rs;
    host_if.req   = 1'b1;
    host_if.we    = 1'b1;
    host_if.addr  = 32'h4;
    host_if.wdata = 32'h0000_0010;
    sgi_req       = 1'b1;
    sgi_code      = 4'd4;
    tick();
    host_if.req   = 1'b0;
    host_if.we    = 1'b0;
    sgi_req       = 1'b0;
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_0010) begin tests_failed++; $display("[TB] FAIL coll_w1c_pend: got %h want 00000010", rd); end
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd4) begin
      tests_failed++; $display("[TB] FAIL coll_deliver: got req=%b code=%0d want req=1 code=4", irq_req, irq_code);
    end
    irq_ack  = 1'b1;
    sgi_req  = 1'b1;
    sgi_code = 4'd4;
    tick();
    irq_ack  = 1'b0;
    sgi_req  = 1'b0;
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_0010) begin tests_failed++; $display("[TB] FAIL coll_ack_pend: got %h want 00000010", rd); end
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd4) begin
      tests_failed++; $display("[TB] FAIL coll_redeliver: got req=%b code=%0d want req=1 code=4", irq_req, irq_code);
    end
    serve();
  endtask

  task automatic test_rearm();
    logic [31:0] rd;
    logic        rs;
    sgi(4'd7);
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd7) begin
      tests_failed++; $display("[TB] FAIL rearm_first: got req=%b code=%0d want req=1 code=7", irq_req, irq_code);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    sgi(4'd7);
    irq_ack = 1'b1;
    host_read(8'h04, rd, rs);
    irq_ack = 1'b0;
    tests_run++;
    if (rd !== 32'h0000_0080) begin tests_failed++; $display("[TB] FAIL rearm_pend: got %h want 00000080", rd); end
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rearm_ack_ignored: got %b want 0", irq_req); end
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tests_run++;
    if (irq_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rearm_idle: got %b want 0", irq_req); end
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd7) begin
      tests_failed++; $display("[TB] FAIL rearm_redeliver: got req=%b code=%0d want req=1 code=7", irq_req, irq_code);
    end
    serve();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    logic        rs;
    host_write(8'h00, 32'h0000_00FF);
    sgi(4'd1);
    tick();
    tests_run++;
    if (irq_req !== 1'b1 || irq_code !== 4'd1) begin
      tests_failed++; $display("[TB] FAIL rst_mid_req: got req=%b code=%0d want req=1 code=1", irq_req, irq_code);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (irq_req !== 1'b0 || irq_code !== 4'd0) begin
      tests_failed++; $display("[TB] FAIL rst_mid_drop: got req=%b code=%0d want req=0 code=0", irq_req, irq_code);
    end
    host_read(8'h04, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_pend: got %h want 0", rd); end
    host_read(8'h00, rd, rs);
    tests_run++;
    if (rd !== 32'h0000_FFFF) begin tests_failed++; $display("[TB] FAIL rst_mid_mask: got %h want 0000ffff", rd); end
    host_read(8'h08, rd, rs);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_stat: got %h want 0", rd); end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    sgi_req       = 1'b0;
    sgi_code      = 4'h0;
    irq_bi        = 16'h0;
    irq_ack       = 1'b0;
    irq_eoi       = 1'b0;
    host_if.req   = 1'b0;
    host_if.we    = 1'b0;
    host_if.addr  = 32'h0;
    host_if.wdata = 32'h0;
    test_reset();
    test_sgi();
    test_priority();
    test_mask();
    test_collision();
    test_rearm();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
